// File: rtl/mem_block_if.sv
// 128-bit block bus between the data cache miss path (master) and the
// block-storage responder (slave).
interface mem_block_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mem_block_responder.sv
// Fixed-latency block memory responder: one read or write at a time, one-cycle
// mem_ready pulse, per-block valid bits so unwritten blocks read back as zero.
module mem_block_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        proc_reset_n,
  mem_block_if.slave  bus,
  output logic        busy,
  output logic        proto_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [3:0]              cnt_r;
  logic [3:0]              cnt_next_s;
  logic                    accept_s;
  logic                    proto_set_s;
  logic                    op_write_r;
  logic [DEPTH_LOG2-1:0]   idx_r;
  logic [127:0]            wdata_r;
  logic [127:0]            rdata_r;
  logic                    ready_r;
  logic                    busy_r;
  logic                    proto_err_r;
  logic [DEPTH-1:0]        valid_r;
  logic [127:0]            mem_r [DEPTH];
  logic                    cur_write_s;
  logic [DEPTH_LOG2-1:0]   cur_idx_s;
  logic                    rd_load_s;
  logic                    arr_wr_s;
  logic                    unused_addr_s;

  // Upper address bits alias onto the same block by design.
  assign unused_addr_s = ^{1'b0, bus.mem_addr[27:DEPTH_LOG2]};

  // Next-state, counter and protocol-check logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    proto_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          accept_s   = 1'b1;
          cnt_next_s = CNT_LOAD;
          if (LATENCY == 1) begin
            state_next_s = ST_RESP;
          end else begin
            state_next_s = ST_WAIT;
          end
          if (bus.mem_read && bus.mem_write) begin
            proto_set_s = 1'b1;
          end else begin
            proto_set_s = 1'b0;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
        if (!bus.mem_read && !bus.mem_write) begin
          proto_set_s = 1'b1;
        end else begin
          proto_set_s = 1'b0;
        end
      end
      ST_RESP: begin
        state_next_s = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.mem_read && !bus.mem_write) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // With LATENCY==1 RESP is entered straight from IDLE, so use the live bus.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_write_s = bus.mem_write;
      cur_idx_s   = bus.mem_addr[DEPTH_LOG2-1:0];
    end else begin
      cur_write_s = op_write_r;
      cur_idx_s   = idx_r;
    end
    rd_load_s = (state_next_s == ST_RESP) && (state_r != ST_RESP) && !cur_write_s;
    arr_wr_s  = (state_r == ST_RESP) && op_write_r;
  end

  // FSM, request latch, response registers and valid bits.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      op_write_r  <= 1'b0;
      idx_r       <= '0;
      wdata_r     <= 128'h0;
      rdata_r     <= 128'h0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      proto_err_r <= 1'b0;
      valid_r     <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (state_next_s == ST_RESP);
      busy_r  <= (state_next_s != ST_IDLE);
      if (accept_s) begin
        op_write_r <= bus.mem_write;
        idx_r      <= bus.mem_addr[DEPTH_LOG2-1:0];
        wdata_r    <= bus.mem_wdata;
      end
      if (proto_set_s) begin
        proto_err_r <= 1'b1;
      end
      if (rd_load_s) begin
        rdata_r <= valid_r[cur_idx_s] ? mem_r[cur_idx_s] : 128'h0;
      end
      if (arr_wr_s) begin
        valid_r[idx_r] <= 1'b1;
      end
    end
  end

  // Block storage data is intentionally not reset; validity lives in valid_r.
  always_ff @(posedge clk) begin
    if (arr_wr_s) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  assign bus.mem_rdata = rdata_r;
  assign bus.mem_ready = ready_r;
  assign busy          = busy_r;
  assign proto_err     = proto_err_r;

endmodule

// File: doc/mem_block_responder.md
# mem_block_responder

Synthesizable memory-side responder for the 128-bit block interface driven by the data cache's miss path (mem_read / mem_write / mem_addr / mem_wdata / mem_rdata / mem_ready). It sits between the cache and the block-storage boundary. It accepts one block read or write at a time and models a fixed access latency with a counter-driven FSM. It returns a one-cycle mem_ready pulse with read data valid in the same cycle.

## Interface
- LATENCY, 4: cycles from request acceptance to the mem_ready cycle; legal range 1..15.
- DEPTH_LOG2, 6: log2 of the number of stored 128-bit blocks; index = mem_addr[DEPTH_LOG2-1:0].
- clk  input  1  sole clock; all state updates on posedge.
- proc_reset_n  input  1  reset, asynchronous, active-low.
- mem_read  input  1  block read request; held by initiator until it observes mem_ready.
- mem_write  input  1  block write request; held by initiator until it observes mem_ready.
- mem_addr  input  28  block address.
- mem_wdata  input  128  write data.
- mem_rdata  output  128  read data; valid in the mem_ready cycle.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high whenever the FSM is not in IDLE.
- proto_err  output  1  sticky protocol-violation flag; cleared only by reset.

## Operation
- Storage: 2^DEPTH_LOG2 × 128-bit array plus a per-block valid bit. Only the valid bits are reset (to 0). A read of a block whose valid bit is 0 returns 128'h0. A write sets the valid bit.
- Address bits above DEPTH_LOG2-1 are ignored, so aliasing is intended.
- FSM states: IDLE, WAIT, RESP, DONE.
- IDLE: if mem_read or mem_write is high, latch the opcode, mem_addr, and mem_wdata.
  - Load the counter with LATENCY-1.
  - Go to RESP if LATENCY==1, else go to WAIT.
  - If both requests are high, perform a write and set proto_err.
- WAIT: decrement the counter. At 1, go to RESP.
  - Bus inputs are ignored; only latched values are used.
  - If both mem_read and mem_write are low in any WAIT cycle, set proto_err. The access still completes.
- RESP: mem_ready=1 for exactly this cycle.
  - Read: mem_rdata = stored block (or 0 if invalid), driven from a register loaded on entry to RESP.
  - Write: the array and valid bit update at the end of the RESP cycle. mem_rdata is unchanged.
  - Next state: DONE unconditionally. The still-asserted request in this cycle is never treated as new.
- DONE: wait for mem_read and mem_write both low, then go to IDLE. A new request is accepted only from IDLE.
- mem_rdata holds its last value outside RESP.

## Timing
- Reset values: mem_ready=0, mem_rdata=128'h0, busy=0, proto_err=0, state=IDLE, counter=0, all valid bits=0.
- Acceptance: request high in IDLE cycle c0 causes mem_ready high in cycle c0+LATENCY and busy high from c0+1 through DONE exit.
- The initiator drops its request in the cycle after mem_ready, so DONE lasts 1 cycle. The earliest next acceptance is c0+LATENCY+2.
- Back-to-back write-back then fill: the fill completes at c0 + 2·LATENCY + 2.
- Read-after-write to the same block in consecutive transactions returns the new data.
- Async reset mid-WAIT or mid-RESP: the FSM goes to IDLE immediately and mem_ready drops immediately.
  - A pending write is discarded.
  - Array data bits are not cleared; valid bits are.
- Request held continuously with no DONE release: the FSM stays in DONE and mem_ready stays 0. This is not an error.

## Test plan
- Read of an unwritten block: addr=28'h0000005, mem_read high at c0, LATENCY=4 -> mem_ready pulses only in c4 with mem_rdata=0; busy high c1..c5.
- Write then read: write addr=28'h12, data=128'hDEADBEEF_00000001_CAFEF00D_12345678; drop request after ready, then read addr 28'h12 -> mem_rdata equals the written data; proto_err=0.
- Cache miss sequence: mem_write (addr A, data D) held until ready, dropped 1 cycle, then mem_read addr B -> two ready pulses spaced LATENCY+2 cycles apart; the later read of A returns D.
- Aliasing: write addr 28'h0000041 with data X (DEPTH_LOG2=6), then read addr 28'h0000001 -> returns X.
- Protocol errors: mem_read and mem_write both high at acceptance -> write performed, proto_err=1 and stays 1. Separately, drop mem_read during WAIT -> proto_err=1 and mem_ready still pulses at c0+LATENCY.
- Reset mid-operation: assert proc_reset_n=0 during WAIT of a write -> mem_ready=0, busy=0 immediately; a subsequent read of that block returns 0.
